// File: rtl/cpu_controller.sv
// Eight-phase control sequencer for a simple accumulator CPU.
// An internal phase counter is decoded into datapath enables. A HLT instruction sets a sticky halted flag.
module cpu_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       inc_pc,
    output logic       ld_pc,
    output logic       ld_ac,
    output logic       wr,
    output logic       data_e,
    output logic       halt,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_e;

    typedef enum logic [2:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_e;

    phase_e  phase_q, phase_d;
    logic    halted_q, halted_d;
    opcode_e op;
    logic    alu_op;

    assign op     = opcode_e'(opcode);
    assign alu_op = (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    assign phase  = phase_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    // When halted, the phase counter freezes at OP_ADDR so that halt stays visible.
    always_comb begin
        phase_d  = phase_q;
        halted_d = halted_q;
        if (!halted_q) begin
            if (phase_q == OP_ADDR && op == OP_HLT) begin
                halted_d = 1'b1;
            end else begin
                phase_d = phase_e'(phase_q + 3'd1);
            end
        end
    end

    // NOTE: every output gets a default first, so no path through the case can infer a latch.
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;
        if (halted_q) begin
            halt = 1'b1;
        end else begin
            case (phase_q)
                INST_ADDR: begin
                    sel = 1'b1;
                end
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = (op == OP_HLT);
                end
                OP_FETCH: begin
                    rd = alu_op;
                end
                ALU_OP: begin
                    rd     = alu_op;
                    inc_pc = (op == OP_SKZ) && zero;
                    ld_pc  = (op == OP_JMP);
                    data_e = (op == OP_STO);
                end
                STORE: begin
                    rd     = alu_op;
                    ld_ac  = alu_op;
                    ld_pc  = (op == OP_JMP);
                    wr     = (op == OP_STO);
                    data_e = (op == OP_STO);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: a reference model pushes the expected output vector each cycle.
// The vector is then popped and compared against the DUT outputs, which are sampled 1 ns later.
module tb_cpu_controller;

    localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, AND_ = 3'd3,
                           XOR_ = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] opcode;
    logic       zero;
    logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
    logic [2:0] phase;

    int n_vec = 0;
    int n_bad = 0;

    logic [11:0] sb[$];
    logic [2:0]  m_phase;
    logic        m_halted;

    cpu_controller dut (
        .clk    (clk),
        .rst    (rst),
        .opcode (opcode),
        .zero   (zero),
        .sel    (sel),
        .rd     (rd),
        .ld_ir  (ld_ir),
        .inc_pc (inc_pc),
        .ld_pc  (ld_pc),
        .ld_ac  (ld_ac),
        .wr     (wr),
        .data_e (data_e),
        .halt   (halt),
        .phase  (phase)
    );

    always #5 clk = ~clk;

    // Packed order: sel rd ld_ir inc_pc ld_pc ld_ac wr data_e halt phase[2:0]
    function automatic logic [11:0] exp_vec(input logic [2:0] ph, input logic hlt_f,
                                            input logic [2:0] op, input logic z);
        logic aluop, e_sel, e_rd, e_ir, e_inc, e_ldpc, e_ldac, e_wr, e_de, e_halt;
        aluop  = (op == ADD) || (op == AND_) || (op == XOR_) || (op == LDA);
        e_sel  = !hlt_f && (ph <= 3'd3);
        e_rd   = !hlt_f && ((ph >= 3'd1 && ph <= 3'd3) || (ph >= 3'd5 && aluop));
        e_ir   = !hlt_f && (ph == 3'd2 || ph == 3'd3);
        e_inc  = !hlt_f && (ph == 3'd4 || (ph == 3'd6 && op == SKZ && z));
        e_ldpc = !hlt_f && (ph >= 3'd6) && (op == JMP);
        e_ldac = !hlt_f && (ph == 3'd7) && aluop;
        e_wr   = !hlt_f && (ph == 3'd7) && (op == STO);
        e_de   = !hlt_f && (ph >= 3'd6) && (op == STO);
        e_halt = hlt_f || (ph == 3'd4 && op == HLT);
        return {e_sel, e_rd, e_ir, e_inc, e_ldpc, e_ldac, e_wr, e_de, e_halt,
                (hlt_f ? 3'd4 : ph)};
    endfunction

    function automatic logic [11:0] dut_vec();
        return {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase};
    endfunction

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (sel rd ir inc ldpc ldac wr de halt ph)",
                     tag, got, exp);
        end
    endtask

    task automatic compare(input string tag);
        logic [11:0] e;
        if (sb.size() == 0) begin
            check({tag, "_empty_sb"}, dut_vec(), 12'hfff);
        end else begin
            e = sb.pop_front();
            check(tag, dut_vec(), e);
        end
    endtask

    // One clock cycle: drive inputs, predict, compare, then advance the model at the edge.
    task automatic step(input string tag, input logic [2:0] op, input logic z);
        opcode = op;
        zero   = z;
        sb.push_back(exp_vec(m_phase, m_halted, op, z));
        #1;
        compare($sformatf("%s_ph%0d", tag, m_phase));
        @(posedge clk);
        if (!m_halted) begin
            if (m_phase == 3'd4 && op == HLT) m_halted = 1'b1;
            else m_phase = m_phase + 3'd1;
        end
        @(negedge clk);
    endtask

    task automatic run_instr(input string tag, input logic [2:0] op, input logic z,
                             input bit scramble);
        for (int i = 0; i < 8; i++) begin
            if (scramble && m_phase <= 3'd3)
                step(tag, 3'($urandom_range(7)), 1'($urandom_range(1)));
            else
                step(tag, op, scramble ? 1'($urandom_range(1)) : z);
        end
    endtask

    task automatic apply_reset(input string tag);
        rst = 1'b1;
        m_phase  = 3'd0;
        m_halted = 1'b0;
        sb.push_back(exp_vec(3'd0, 1'b0, opcode, zero));
        #1;
        compare({tag, "_async"});
        @(posedge clk);
        sb.push_back(exp_vec(3'd0, 1'b0, opcode, zero));
        #1;
        compare({tag, "_held"});
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        opcode = ADD;
        zero   = 1'b0;
        m_phase  = 3'd0;
        m_halted = 1'b0;
        #12;
        sb.push_back(exp_vec(3'd0, 1'b0, ADD, 1'b0));
        compare("reset");
        @(negedge clk);
        rst = 1'b0;

        run_instr("add", ADD, 1'b0, 1'b0);
        run_instr("sto", STO, 1'b0, 1'b0);
        run_instr("skz1", SKZ, 1'b1, 1'b0);
        run_instr("skz0", SKZ, 1'b0, 1'b0);
        run_instr("jmp", JMP, 1'b1, 1'b0);
        run_instr("lda", LDA, 1'b0, 1'b0);
        run_instr("and", AND_, 1'b1, 1'b0);
        run_instr("xor", XOR_, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++)
            run_instr("rand", 3'($urandom_range(7, 1)), 1'b0, 1'b1);

        // Abort a store mid-phase 6 with an asynchronous reset.
        for (int i = 0; i < 6; i++) step("sto_abort", STO, 1'b0);
        opcode = STO;
        #2;
        apply_reset("rst_ph6");
        run_instr("post_rst", ADD, 1'b0, 1'b0);

        // Halt: phase freezes at 4 for well over 20 cycles.
        for (int i = 0; i < 5; i++) step("hlt", HLT, 1'b0);
        for (int i = 0; i < 24; i++) step("halted", 3'($urandom_range(7)), 1'($urandom_range(1)));
        #3;
        apply_reset("rst_halted");
        run_instr("after_halt", JMP, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 The block SHALL have exactly one clock domain and an asynchronous, active-high reset.
REQ-002 clk  input  1  System clock; all state updates on the rising edge.
REQ-003 rst  input  1  Asynchronous active-high reset.
REQ-004 opcode  input  3  Instruction opcode from the instruction register (HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111).
REQ-005 zero  input  1  Accumulator-zero flag from the ALU (is_zero), combinational.
REQ-006 sel  output  1  Address mux select: 1 = program counter, 0 = instruction operand address.
REQ-007 rd  output  1  Memory read enable.
REQ-008 ld_ir  output  1  Instruction register load enable.
REQ-009 inc_pc  output  1  Program counter increment enable.
REQ-010 ld_pc  output  1  Program counter load enable (jump).
REQ-011 ld_ac  output  1  Accumulator load enable from ALU output.
REQ-012 wr  output  1  Memory write enable.
REQ-013 data_e  output  1  Accumulator-to-data-bus drive enable.
REQ-014 halt  output  1  CPU halted indication.
REQ-015 phase  output  3  Current phase number, 0..7.

Function
REQ-016 The block SHALL hold a 3-bit phase register advancing by one per clk cycle and wrapping from 7 to 0.
REQ-017 Phases SHALL be: 0 INST_ADDR, 1 INST_FETCH, 2 INST_LOAD, 3 IDLE, 4 OP_ADDR, 5 OP_FETCH, 6 ALU_OP, 7 STORE.
REQ-018 ALUOP SHALL be defined as opcode in {ADD, AND, XOR, LDA}.
REQ-019 Outputs SHALL be a combinational decode of phase, opcode, zero, and the halted flag; any output not listed for a phase SHALL be 0.
REQ-020 Phase 0: sel=1.
REQ-021 Phase 1: sel=1, rd=1.
REQ-022 Phases 2 and 3: sel=1, rd=1, ld_ir=1.
REQ-023 Phase 4: inc_pc=1, and halt=1 when opcode=HLT.
REQ-024 Phase 5: rd=ALUOP.
REQ-025 Phase 6: rd=ALUOP, inc_pc=(opcode=SKZ and zero=1), ld_pc=(opcode=JMP), data_e=(opcode=STO).
REQ-026 Phase 7: rd=ALUOP, ld_ac=ALUOP, ld_pc=(opcode=JMP), wr=(opcode=STO), data_e=(opcode=STO).
REQ-027 A rising clk edge in phase 4 with opcode=HLT SHALL set a sticky halted flag.
REQ-028 While halted, phase SHALL freeze at 4 and halt SHALL be 1.
REQ-029 While halted, all outputs other than halt and phase SHALL be 0, so inc_pc does not repeat.
REQ-030 The halted flag SHALL clear only on rst.
REQ-031 opcode and zero SHALL be used combinationally.
REQ-032 Opcode changes in phases 0-3 SHALL affect only the phase-4..7 decode.
REQ-033 wr and ld_pc SHALL never be asserted in phases 0-5.
REQ-034 rd and wr SHALL never be 1 in the same cycle.
REQ-035 SKZ with zero=0 SHALL produce no extra inc_pc.
REQ-036 Each instruction SHALL take exactly 8 cycles, with no stalls or handshakes.

Reset
REQ-037 While rst=1, phase SHALL be 0 and the halted flag SHALL be 0, independent of clk.
REQ-038 During and immediately after reset, outputs SHALL be sel=1 and all other control outputs 0.
REQ-039 Reset asserted mid-instruction (any phase, including halted) SHALL abort it immediately, with no write or PC load completing.
REQ-040 On the first rising clk after rst deasserts, phase SHALL go to 1.

Verification
REQ-041 Reset then opcode=ADD, 8 cycles -> phase 0..7 in sequence; ld_ir=1 in phases 2-3; inc_pc=1 only in phase 4; rd=1 in phases 1-3 and 5-7; ld_ac=1 only in phase 7; back to phase 0 at cycle 8.
REQ-042 opcode=STO -> data_e=1 in phases 6-7; wr=1 only in phase 7; rd=0 in phases 5-7.
REQ-043 opcode=SKZ with zero=1 -> inc_pc=1 in phases 4 and 6; with zero=0 -> inc_pc=1 only in phase 4.
REQ-044 opcode=JMP -> ld_pc=1 in phases 6-7 and inc_pc=1 only in phase 4; opcode=LDA -> ld_ac=1 in phase 7.
REQ-045 opcode=HLT -> halt=1 from phase 4; phase stays 4 for 20+ cycles; inc_pc=0 after the first halted edge; rst -> phase=0, halt=0.
REQ-046 rst pulsed asynchronously mid-phase 6 with opcode=STO -> phase=0 immediately; wr never asserts; sel=1.
